// File: rtl/interrupt_controller.sv
// Request side of the CPU interrupt handshake: edge-captures peripheral and NMI requests,
// prioritises maskable lines, drives INT/NMI and tracks in-service state until EOI.
module interrupt_controller #(
    parameter int unsigned NUM_IRQ = 8,
    parameter int unsigned VEC_W   = 3
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic [NUM_IRQ-1:0] IRQ,
    input  logic               NMI_Src,
    input  logic               MaskWrite,
    input  logic [NUM_IRQ-1:0] MaskData,
    input  logic               INTD,
    input  logic               isInterrupted,
    input  logic               INA,
    input  logic               EOI,
    output logic               INT,
    output logic               NMI,
    output logic [VEC_W-1:0]   Vector,
    output logic [NUM_IRQ-1:0] InService,
    output logic               NMIActive
);

    typedef enum logic [2:0] {
        StIdle,
        StIntReq,
        StNmiReq,
        StIntSvc,
        StNmiSvc
    } state_e;

    state_e               state_q, state_d;
    logic [NUM_IRQ-1:0]   mask_q;
    logic [NUM_IRQ-1:0]   pending_q, pending_d;
    logic                 nmi_pend_q, nmi_pend_d;
    logic [NUM_IRQ-1:0]   irq_prev_q;
    logic                 nmi_src_prev_q;
    logic                 ack_prev_q;
    logic                 int_q, int_d;
    logic                 nmi_q, nmi_d;
    logic [VEC_W-1:0]     vector_q, vector_d;
    logic [NUM_IRQ-1:0]   in_service_q, in_service_d;
    logic                 nmi_active_q, nmi_active_d;

    logic [NUM_IRQ-1:0]   irq_rise;
    logic                 nmi_rise;
    logic                 ack;
    logic [NUM_IRQ-1:0]   eligible;
    logic                 any_eligible;
    logic [VEC_W-1:0]     winner;
    logic [NUM_IRQ-1:0]   vec_onehot;
    logic [NUM_IRQ-1:0]   pend_clr;
    logic                 npend_clr;

    assign irq_rise     = IRQ & ~irq_prev_q;
    assign nmi_rise     = NMI_Src & ~nmi_src_prev_q;
    assign ack          = isInterrupted & ~ack_prev_q;
    assign eligible     = pending_q & mask_q;
    assign any_eligible = |eligible;
    assign vec_onehot   = NUM_IRQ'(1) << vector_q;

    // Scan from the top so the lowest set index is the one left standing.
    always_comb begin
        winner = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                winner = VEC_W'(i);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        pend_clr     = '0;
        npend_clr    = 1'b0;
        int_d        = 1'b0;
        vector_d     = vector_q;
        in_service_d = in_service_q;
        nmi_active_d = nmi_active_q;

        case (state_q)
            StIdle: begin
                if (nmi_pend_q) begin
                    state_d = StNmiReq;
                end else if (any_eligible && !INTD) begin
                    state_d  = StIntReq;
                    vector_d = winner;
                    int_d    = 1'b1;
                end
            end
            StIntReq: begin
                if (ack && INA) begin
                    state_d      = StIntSvc;
                    pend_clr     = vec_onehot;
                    in_service_d = vec_onehot;
                end else if (ack) begin
                    // The CPU took the NMI instead; the maskable line stays pending.
                    state_d      = StNmiSvc;
                    npend_clr    = 1'b1;
                    nmi_active_d = 1'b1;
                end else if (INTD || !mask_q[vector_q]) begin
                    state_d = StIdle;
                end else begin
                    int_d = 1'b1;
                end
            end
            StNmiReq: begin
                if (ack) begin
                    state_d      = StNmiSvc;
                    npend_clr    = 1'b1;
                    nmi_active_d = 1'b1;
                end
            end
            StIntSvc: begin
                if (ack && !INA) begin
                    state_d      = StNmiSvc;
                    npend_clr    = 1'b1;
                    nmi_active_d = 1'b1;
                end else if (EOI) begin
                    state_d      = StIdle;
                    in_service_d = '0;
                end
            end
            StNmiSvc: begin
                if (EOI) begin
                    nmi_active_d = 1'b0;
                    state_d      = (|in_service_q) ? StIntSvc : StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // NMI follows the pending flag everywhere except around the NMI handler itself.
        nmi_d      = (state_q != StNmiSvc && state_d != StNmiSvc) ? nmi_pend_q : 1'b0;
        pending_d  = (pending_q & ~pend_clr) | irq_rise;
        nmi_pend_d = (nmi_pend_q & ~npend_clr) | nmi_rise;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q        <= StIdle;
            mask_q         <= '0;
            pending_q      <= '0;
            nmi_pend_q     <= 1'b0;
            irq_prev_q     <= '0;
            nmi_src_prev_q <= 1'b0;
            ack_prev_q     <= 1'b0;
            int_q          <= 1'b0;
            nmi_q          <= 1'b0;
            vector_q       <= '0;
            in_service_q   <= '0;
            nmi_active_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            if (MaskWrite) begin
                mask_q <= MaskData;
            end
            pending_q      <= pending_d;
            nmi_pend_q     <= nmi_pend_d;
            irq_prev_q     <= IRQ;
            nmi_src_prev_q <= NMI_Src;
            ack_prev_q     <= isInterrupted;
            int_q          <= int_d;
            nmi_q          <= nmi_d;
            vector_q       <= vector_d;
            in_service_q   <= in_service_d;
            nmi_active_q   <= nmi_active_d;
        end
    end

    assign INT       = int_q;
    assign NMI       = nmi_q;
    assign Vector    = vector_q;
    assign InService = in_service_q;
    assign NMIActive = nmi_active_q;

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Request side of the CPU interrupt handshake: collects peripheral interrupt lines and an external NMI source, then drives the controller's INT and NMI inputs.
- Consumes the CPU's acknowledge (isInterrupted, INA) and interrupt-disable (INTD) status.
- Prioritises maskable requests, presents a latched vector, and tracks in-service state until software signals end-of-interrupt (EOI).
- Sits between the peripheral bus and the CPU controller.

Parameters:
- NUM_IRQ, 8, number of maskable interrupt lines; index 0 is the highest priority.
- VEC_W, 3, width of Vector; must equal ceil(log2(NUM_IRQ)).

Ports:
- Clk  input  1  system clock; all state updates on its rising edge.
- Rst_n  input  1  reset, asynchronous and active-low.
- IRQ  input  NUM_IRQ  peripheral requests, synchronous to Clk; a rising edge of a bit requests service.
- NMI_Src  input  1  non-maskable source, synchronous; a rising edge requests service.
- MaskWrite  input  1  when 1, Mask is loaded from MaskData.
- MaskData  input  NUM_IRQ  new enable mask; bit=1 means enabled.
- INTD  input  1  CPU interrupt-disable status; blocks maskable requests only.
- isInterrupted  input  1  CPU acknowledge level; its rising edge is the acknowledge.
- INA  input  1  valid with the acknowledge: 1 = maskable interrupt taken, 0 = NMI taken.
- EOI  input  1  single-cycle end-of-interrupt pulse from software.
- INT  output  1  maskable request to the CPU.
- NMI  output  1  non-maskable request to the CPU.
- Vector  output  VEC_W  index of the requested or serviced maskable line.
- InService  output  NUM_IRQ  one-hot in-service maskable line.
- NMIActive  output  1  NMI handler in progress.

Behaviour:
- Reset (asynchronous, Rst_n=0) sets the following, all taking effect immediately:
  - INT=0, NMI=0, Vector=0, InService=0, NMIActive=0.
  - Mask=0, Pending=0, NMIPend=0.
  - IRQ, NMI_Src and isInterrupted previous-value registers = 0.
  - State = IDLE.
- Edge capture, every cycle:
  - Pending[i] is set on a 0->1 transition of IRQ[i]; a line held high does not re-request.
  - NMIPend is set on a 0->1 transition of NMI_Src.
  - When a set and a clear of the same bit occur in the same cycle, the set wins.
- Mask register: MaskWrite loads MaskData on the next edge. Masking does not clear Pending.
- Eligible = Pending & Mask. The winner is the lowest-index set bit of Eligible.
- Ack = isInterrupted & ~isInterrupted_prev, a one-cycle internal strobe.
- IDLE:
  - NMIPend=1 -> NMI_REQ, with NMI=1 from the next cycle.
  - Otherwise, if Eligible!=0 and INTD=0 -> INT_REQ; Vector latches the winner, INT=1 from the next cycle.
  - NMI takes priority when both are possible in the same cycle.
- INT_REQ:
  - INT held at 1; Vector frozen.
  - Ack with INA=1 -> INT_SVC: clear Pending[Vector], set InService[Vector], INT=0.
  - Ack with INA=0 (NMI won at the CPU): handled as in NMI_REQ.
  - NMIPend rising while in INT_REQ: NMI=1 as well, and the state stays INT_REQ.
  - INTD=1 or Mask[Vector]=0 without an Ack -> INT=0, return to IDLE; Pending is retained.
- NMI_REQ:
  - NMI=1.
  - Ack (any INA) -> NMI_SVC: NMIPend=0, NMI=0, NMIActive=1.
- INT_SVC:
  - INT=0. New maskable requests are only pended; there is no maskable nesting.
  - NMIPend=1 -> NMI=1; Ack with INA=0 -> NMI_SVC, keeping InService unchanged.
  - EOI -> InService=0, return to IDLE.
- NMI_SVC:
  - EOI -> NMIActive=0.
  - Next state is INT_SVC if InService!=0, else IDLE.
  - A new NMI edge during NMI_SVC is pended only and is presented after exit.
- EOI in IDLE, INT_REQ or NMI_REQ is ignored.
- An Ack in IDLE, or an Ack in INT_SVC with INA=1, is ignored (spurious).
- Latency: a request edge at cycle n gives INT/NMI high at cycle n+2 from IDLE (capture, then decide). Ack at cycle m drops the request at cycle m+1.
- Outputs are registered; there are no combinational paths from inputs to INT, NMI or Vector.
- Reset asserted mid-handshake aborts everything to reset values; the requests must be re-raised.

Test Plan:
- Mask=8'hFF, IRQ[5] rises at cycle 10 -> INT=1 and Vector=5 at cycle 12; isInterrupted rises with INA=1 -> INT=0 next cycle, InService=8'h20; EOI -> InService=0, IDLE.
- IRQ[6] and IRQ[2] rise in the same cycle, Mask=8'hFF -> Vector=2; after Ack+EOI, INT reasserts with Vector=6.
- Mask=8'hFB, IRQ[2] rises -> no INT; write Mask=8'hFF -> INT=1, Vector=2. Then INTD=1 before the Ack -> INT=0, Pending[2] kept; INTD=0 -> INT=1 again.
- IRQ[1] in service, NMI_Src rises -> NMI=1; Ack with INA=0 -> NMIActive=1, InService=8'h02; EOI -> NMIActive=0, InService=8'h02; second EOI -> IDLE.
- IRQ[3] and NMI_Src rise in the same cycle -> NMI=1 and INT=0; after NMI Ack+EOI, INT=1 with Vector=3.
- Rst_n pulled low while INT=1 -> INT, Vector, InService and Pending clear immediately; IRQ held high after reset -> no INT.
